elastic_pipe_v1_0: RTL and testbench
====================================

# elastic_pipe_v1_0

Parameterised elastic (valid/ready) pipeline register chain with bubble collapse, an input skid register and a fully registered `D_READY`. It sits upstream of the fixed-latency, CE-gated baseblock pipelines. It converts a back-pressured producer stream into stall-tolerant, in-order delivery so downstream stages never lose or duplicate a word. Occupancy is exported for flow-control monitoring.

## Interface
- `C_WIDTH`, 16, data width in bits (1..256).
- `C_PIPE_STAGES`, 2, number of data stages N (1..14).
- `C_SINIT_VAL`, "", binary string of `C_WIDTH` chars loaded into every data register on `SCLR`. An empty string means all zeros; any char other than '0'/'1' is a fatal elaboration error.
- `CLK`  in  1  clock; all state changes on rising edge.
- `SCLR`  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
- `D`  in  C_WIDTH  input data.
- `D_VALID`  in  1  producer offers `D`.
- `D_READY`  out  1  block accepts `D` this cycle.
- `Q`  out  C_WIDTH  output data, meaningful only when `Q_VALID`=1.
- `Q_VALID`  out  1  output word present.
- `Q_READY`  in  1  consumer takes `Q` this cycle.
- `FLUSH`  in  1  synchronous discard of all held words.
- `COUNT`  out  4  words held (stages plus skid), 0..N+1.

## Operation
- State:
  - data stages S[0..N-1], each with valid bit V[i];
  - skid register K with valid bit KV.
  - `Q`=S[N-1], `Q_VALID`=V[N-1].
- Advance terms (combinational):
  - adv[N-1] = `Q_READY` | !V[N-1];
  - adv[i] = adv[i+1] | !V[i] for i<N-1.
  - A bubble is therefore always filled, even while the output stalls.
- Stage move: when adv[i], for i≥1, V[i] <= V[i-1]. S[i] <= S[i-1] only if V[i-1]=1; otherwise the data is held, so no toggling on bubbles.
- Accept: acc = `D_VALID` & `D_READY`. `D_READY` = !KV & !`SCLR` & !`FLUSH`. KV is a register, so `D_READY` never depends combinationally on `Q_READY`.
- Stage 0 when adv[0]:
  - if KV, then S0<=K, V0<=1, KV<=0;
  - else if acc, then S0<=D, V0<=1;
  - else V0<=0.
- Skid: when acc & !adv[0], K<=D, KV<=1. KV and acc are never both 1.
- `COUNT` = KV + ΣV[i], registered, updated with the state.
- Ordering: strictly FIFO; no word dropped or duplicated outside `FLUSH`/`SCLR`.
- `FLUSH`:
  - clears all V[i] and KV at the edge;
  - data registers hold;
  - no word is accepted in a flush cycle, because `D_READY`=0;
  - a word presented at `Q` in the flush cycle counts as transferred only if `Q_READY`=1.
- `SCLR`:
  - highest priority over everything;
  - at the edge, all V, KV and `COUNT` go to 0, and all S and K go to the SINIT value;
  - `D_READY`=0 during the `SCLR` cycle;
  - `FLUSH` in the same cycle is redundant.

## Timing
- Reset values (after `SCLR` edge): `Q_VALID`=0, `COUNT`=0, `Q`=SINIT value, `D_READY`=1 from the first cycle with `SCLR`=0.
- Latency, empty chain: `D` accepted in cycle t appears with `Q_VALID`=1 in cycle t+N.
- Throughput: 1 word/cycle sustained with `Q_READY` held 1, and `COUNT` steady at N.
- Stall: capacity is N+1 words. `D_READY` falls the cycle after the (N+1)th accept. It rises the cycle after the edge on which K drains into S0.
- Output transfer occurs on an edge where `Q_VALID` & `Q_READY`. With `Q_READY`=0, `Q`/`Q_VALID` are stable.
- Reset mid-stream: held words are lost and there is no partial transfer. A `Q_READY`=1 in the `SCLR` cycle does not count as a transfer.

## Test plan
- Reset: C_WIDTH=16, C_SINIT_VAL="0000000010100101", pulse `SCLR` 1 cycle -> `Q`=0x00A5, `Q_VALID`=0, `COUNT`=0, `D_READY`=1 the next cycle.
- Stream: N=3, `D`=1,2,3,… with `D_VALID`=1 from cycle 0 and `Q_READY`=1 -> `Q_VALID` first high in cycle 3, `Q`=1,2,3,… consecutive, `COUNT`=3 steady, `D_READY` never low.
- Back-pressure: N=3, `Q_READY`=0, offer 1..5 -> 4 accepted, `D_READY`=0 from the cycle after the 4th accept, `COUNT`=4. Release `Q_READY` -> `Q`=1,2,3,4 in order, word 5 accepted, `D_READY`=1 one cycle after K drains.
- Bubble collapse: N=4, `Q_READY`=0, send A, idle 2 cycles, send B -> A at `Q`, B in S[2] within 2 further cycles, `COUNT`=2. Release -> A then B on consecutive cycles.
- Flush: N=3, `COUNT`=3, assert `FLUSH` 1 cycle with `D_VALID`=1, `D`=0x55 -> next cycle `COUNT`=0, `Q_VALID`=0; 0x55 never appears at `Q`.
- Reset collision: `SCLR`=1 with `D_VALID`=1, `Q_READY`=1, `COUNT`=2 -> no transfer either side, `COUNT`=0 after the edge.

Source files
------------

// File: rtl/elastic_pipe_v1_0.sv
// elastic_pipe_v1_0: valid/ready register chain with bubble collapse, an input
// skid register and a D_READY that depends only on registered state, SCLR and FLUSH.
module elastic_pipe_v1_0 #(
   parameter int                   C_WIDTH       = 16,
   parameter int                   C_PIPE_STAGES = 2,
   parameter logic [8*C_WIDTH-1:0] C_SINIT_VAL   = ""
) (
   input  logic               CLK,
   input  logic               SCLR,
   input  logic [C_WIDTH-1:0] D,
   input  logic               D_VALID,
   output logic               D_READY,
   output logic [C_WIDTH-1:0] Q,
   output logic               Q_VALID,
   input  logic               Q_READY,
   input  logic               FLUSH,
   output logic [3:0]         COUNT
);
   localparam int N = C_PIPE_STAGES;

   // Rightmost character of the string is bit 0; 8'h30/8'h31 are ASCII '0'/'1'.
   function automatic logic [C_WIDTH-1:0] sinit_bits(input logic [8*C_WIDTH-1:0] s);
      logic [C_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < C_WIDTH; i++)
         v[i] = (s[8*i +: 8] == 8'h31);
      return v;
   endfunction

   function automatic logic sinit_legal(input logic [8*C_WIDTH-1:0] s);
      logic ok;
      ok = 1'b1;
      if (s != '0)
         for (int i = 0; i < C_WIDTH; i++)
            if (s[8*i +: 8] != 8'h30 && s[8*i +: 8] != 8'h31)
               ok = 1'b0;
      return ok;
   endfunction

   localparam logic [C_WIDTH-1:0] SINIT    = sinit_bits(C_SINIT_VAL);
   localparam logic               SINIT_OK = sinit_legal(C_SINIT_VAL);

   generate
      if (!SINIT_OK) begin : g_bad_sinit
         $fatal(1, "elastic_pipe_v1_0: C_SINIT_VAL may contain only '0' and '1'");
      end
      if (N < 1 || N > 14 || C_WIDTH < 1 || C_WIDTH > 256) begin : g_bad_size
         $fatal(1, "elastic_pipe_v1_0: C_WIDTH or C_PIPE_STAGES out of range");
      end
   endgenerate

   logic [C_WIDTH-1:0] stage_q [N];
   logic [N-1:0]       vld_q;
   logic [C_WIDTH-1:0] skid_q;
   logic               skid_vld_q;
   logic [3:0]         count_q;

   logic [N-1:0]       adv;
   logic               acc;
   logic [N-1:0]       vld_nxt;
   logic               skid_vld_nxt;
   logic [3:0]         count_nxt;

   // A stage may advance if the one ahead advances or it holds a bubble.
   always_comb begin
      adv      = '0;
      adv[N-1] = Q_READY | ~vld_q[N-1];
      for (int i = N - 2; i >= 0; i--)
         adv[i] = adv[i+1] | ~vld_q[i];
   end

   assign D_READY = ~skid_vld_q & ~SCLR & ~FLUSH;
   assign acc     = D_VALID & D_READY;

   always_comb begin
      vld_nxt      = vld_q;
      skid_vld_nxt = skid_vld_q;
      for (int i = N - 1; i >= 1; i--)
         if (adv[i])
            vld_nxt[i] = vld_q[i-1];
      if (adv[0]) begin
         vld_nxt[0]   = skid_vld_q | acc;
         skid_vld_nxt = 1'b0;
      end else if (acc) begin
         skid_vld_nxt = 1'b1;
      end
      if (FLUSH) begin
         vld_nxt      = '0;
         skid_vld_nxt = 1'b0;
      end
      count_nxt = {3'b000, skid_vld_nxt};
      for (int i = 0; i < N; i++)
         count_nxt = count_nxt + {3'b000, vld_nxt[i]};
   end

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         vld_q      <= '0;
         skid_vld_q <= 1'b0;
         count_q    <= '0;
         skid_q     <= SINIT;
         for (int i = 0; i < N; i++)
            stage_q[i] <= SINIT;
      end else begin
         vld_q      <= vld_nxt;
         skid_vld_q <= skid_vld_nxt;
         count_q    <= count_nxt;
         // Data only moves behind a valid word, so bubbles never toggle registers.
         if (!FLUSH) begin
            for (int i = 1; i < N; i++)
               if (adv[i] && vld_q[i-1])
                  stage_q[i] <= stage_q[i-1];
            if (adv[0]) begin
               if (skid_vld_q)
                  stage_q[0] <= skid_q;
               else if (acc)
                  stage_q[0] <= D;
            end else if (acc) begin
               skid_q <= D;
            end
         end
      end
   end

   assign Q       = stage_q[N-1];
   assign Q_VALID = vld_q[N-1];
   assign COUNT   = count_q;

endmodule

// File: tb/tb_elastic_pipe_v1_0.sv
// Bench for elastic_pipe_v1_0: directed tables/sequences on N=3 and N=4 chains
// plus random traffic against a queue-based latency/capacity model.
module tb_elastic_pipe_v1_0;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_sclr = 1'b1, a_dv = 1'b0, a_qr = 1'b0, a_flush = 1'b0;
   logic [15:0] a_d = '0;
   logic        a_dr, a_qv;
   logic [15:0] a_q;
   logic [3:0]  a_cnt;

   logic        b_sclr = 1'b1, b_dv = 1'b0, b_qr = 1'b0, b_flush = 1'b0;
   logic [15:0] b_d = '0;
   logic        b_dr, b_qv;
   logic [15:0] b_q;
   logic [3:0]  b_cnt;

   elastic_pipe_v1_0 #(
      .C_WIDTH(16), .C_PIPE_STAGES(3), .C_SINIT_VAL("0000000010100101")
   ) dut_a (
      .CLK(clk), .SCLR(a_sclr), .D(a_d), .D_VALID(a_dv), .D_READY(a_dr),
      .Q(a_q), .Q_VALID(a_qv), .Q_READY(a_qr), .FLUSH(a_flush), .COUNT(a_cnt)
   );

   elastic_pipe_v1_0 #(
      .C_WIDTH(16), .C_PIPE_STAGES(4)
   ) dut_b (
      .CLK(clk), .SCLR(b_sclr), .D(b_d), .D_VALID(b_dv), .D_READY(b_dr),
      .Q(b_q), .Q_VALID(b_qv), .Q_READY(b_qr), .FLUSH(b_flush), .COUNT(b_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc_a(input logic sclr, input logic dv, input logic [15:0] d,
                        input logic qr, input logic fl);
      @(negedge clk);
      a_sclr = sclr; a_dv = dv; a_d = d; a_qr = qr; a_flush = fl;
      #1;
   endtask

   task automatic cyc_b(input logic sclr, input logic dv, input logic [15:0] d,
                        input logic qr, input logic fl);
      @(negedge clk);
      b_sclr = sclr; b_dv = dv; b_d = d; b_qr = qr; b_flush = fl;
      #1;
   endtask

   typedef struct {
      logic        dv;
      logic [15:0] d;
      logic        qr;
      logic        exp_dr;
      logic        exp_qv;
      logic        chk_q;
      logic [15:0] exp_q;
      logic [3:0]  exp_cnt;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      int          vis;
   } ent_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t bp_tab[12];
      ent_t mq[$];
      ent_t e;
      int   cyc;
      logic sclr, fl, dv, qr, exp_dr, exp_qv;
      logic [15:0] d;

      // Back-pressure on N=3: four words fit, fifth waits for the skid to drain.
      bp_tab = '{
         '{1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A5, 4'd0},
         '{1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A5, 4'd1},
         '{1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A5, 4'd2},
         '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1,    4'd3},
         '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1,    4'd4},
         '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1,    4'd4},
         '{1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1,    4'd4},
         '{1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2,    4'd3},
         '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd3,    4'd3},
         '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd4,    4'd2},
         '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5,    4'd1},
         '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,    4'd0}
      };

      // Reset with SINIT pattern
      cyc_a(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
      chk("rst_d_ready_in_sclr", 32'(a_dr), 32'd0);
      cyc_a(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("rst_q", 32'(a_q), 32'h00A5);
      chk("rst_q_valid", 32'(a_qv), 32'd0);
      chk("rst_count", 32'(a_cnt), 32'd0);
      chk("rst_d_ready", 32'(a_dr), 32'd1);

      // Back-pressure table (first row is the cycle right after reset)
      cyc_a(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cyc_a(1'b0, bp_tab[i].dv, bp_tab[i].d, bp_tab[i].qr, 1'b0);
         chk($sformatf("bp%0d_d_ready", i), 32'(a_dr), 32'(bp_tab[i].exp_dr));
         chk($sformatf("bp%0d_q_valid", i), 32'(a_qv), 32'(bp_tab[i].exp_qv));
         chk($sformatf("bp%0d_count", i), 32'(a_cnt), 32'(bp_tab[i].exp_cnt));
         if (bp_tab[i].chk_q)
            chk($sformatf("bp%0d_q", i), 32'(a_q), 32'(bp_tab[i].exp_q));
      end

      // Streaming at full rate
      cyc_a(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         cyc_a(1'b0, 1'b1, 16'(c + 1), 1'b1, 1'b0);
         chk($sformatf("stream%0d_d_ready", c), 32'(a_dr), 32'd1);
         chk($sformatf("stream%0d_q_valid", c), 32'(a_qv), (c >= 3) ? 32'd1 : 32'd0);
         chk($sformatf("stream%0d_count", c), 32'(a_cnt), (c < 3) ? 32'(c) : 32'd3);
         if (c >= 3)
            chk($sformatf("stream%0d_q", c), 32'(a_q), 32'(c - 2));
      end

      // Flush with a word offered in the flush cycle
      cyc_a(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b1, 16'h0022, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b1, 16'h0033, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("flush_pre_count", 32'(a_cnt), 32'd3);
      chk("flush_pre_q", 32'(a_q), 32'h0011);
      cyc_a(1'b0, 1'b1, 16'h0055, 1'b0, 1'b1);
      chk("flush_d_ready", 32'(a_dr), 32'd0);
      for (int k = 0; k < 5; k++) begin
         cyc_a(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
         chk($sformatf("flush_post%0d_count", k), 32'(a_cnt), 32'd0);
         chk($sformatf("flush_post%0d_q_valid", k), 32'(a_qv), 32'd0);
         chk($sformatf("flush_post%0d_q_held", k), 32'(a_q), 32'h0011);
      end
      cyc_a(1'b0, 1'b1, 16'h0066, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         cyc_a(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
         chk($sformatf("flush_refill%0d_q_valid", k), 32'(a_qv), (k == 3) ? 32'd1 : 32'd0);
      end
      chk("flush_refill_q", 32'(a_q), 32'h0066);

      // Reset colliding with traffic on both sides
      cyc_a(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b1, 16'h0071, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b1, 16'h0072, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_a(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("coll_pre_count", 32'(a_cnt), 32'd2);
      chk("coll_pre_q", 32'(a_q), 32'h0071);
      cyc_a(1'b1, 1'b1, 16'h0099, 1'b1, 1'b0);
      chk("coll_d_ready", 32'(a_dr), 32'd0);
      for (int k = 0; k < 5; k++) begin
         cyc_a(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
         chk($sformatf("coll_post%0d_q_valid", k), 32'(a_qv), 32'd0);
         chk($sformatf("coll_post%0d_count", k), 32'(a_cnt), 32'd0);
      end
      chk("coll_post_q", 32'(a_q), 32'h00A5);

      // Bubble collapse on N=4 with default (zero) SINIT
      cyc_b(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_b(1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0);
      chk("bub_rst_q", 32'(b_q), 32'd0);
      chk("bub_rst_count", 32'(b_cnt), 32'd0);
      chk("bub_rst_d_ready", 32'(b_dr), 32'd1);
      cyc_b(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_b(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_b(1'b0, 1'b1, 16'h00BB, 1'b0, 1'b0);
      chk("bub_c3_q_valid", 32'(b_qv), 32'd0);
      for (int k = 4; k <= 5; k++) begin
         cyc_b(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
         chk($sformatf("bub_c%0d_q_valid", k), 32'(b_qv), 32'd1);
         chk($sformatf("bub_c%0d_q", k), 32'(b_q), 32'h00AA);
         chk($sformatf("bub_c%0d_count", k), 32'(b_cnt), 32'd2);
      end
      cyc_b(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc_b(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("bub_rel_q_a", 32'(b_q), 32'h00AA);
      cyc_b(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("bub_rel_q_valid_b", 32'(b_qv), 32'd1);
      chk("bub_rel_q_b", 32'(b_q), 32'h00BB);
      chk("bub_rel_count_b", 32'(b_cnt), 32'd1);
      cyc_b(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("bub_empty_q_valid", 32'(b_qv), 32'd0);
      chk("bub_empty_count", 32'(b_cnt), 32'd0);

      // Random traffic: FIFO of {word, first cycle it may show at Q}
      cyc_a(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc = 0;
      for (int k = 0; k < 800; k++) begin
         sclr = ($urandom_range(0, 99) < 2);
         fl   = ($urandom_range(0, 99) < 3);
         dv   = ($urandom_range(0, 99) < 75);
         qr   = ($urandom_range(0, 99) < ((k < 400) ? 35 : 85));
         d    = 16'($urandom);
         cyc_a(sclr, dv, d, qr, fl);
         exp_dr = (mq.size() < 4) && !sclr && !fl;
         exp_qv = (mq.size() > 0) && (mq[0].vis <= cyc);
         chk("rnd_d_ready", 32'(a_dr), 32'(exp_dr));
         chk("rnd_q_valid", 32'(a_qv), 32'(exp_qv));
         chk("rnd_count", 32'(a_cnt), 32'(mq.size()));
         if (exp_qv)
            chk("rnd_q", 32'(a_q), 32'(mq[0].d));
         if (sclr || fl) begin
            mq.delete();
         end else begin
            if (exp_qv && qr) begin
               void'(mq.pop_front());
               if (mq.size() > 0 && mq[0].vis < cyc + 1)
                  mq[0].vis = cyc + 1;
            end
            if (dv && exp_dr) begin
               e.d   = d;
               e.vis = cyc + 3;
               mq.push_back(e);
            end
         end
         cyc++;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
